// File: rtl/grf_write_arbiter_pkg.sv
// Shared GRF writeback types: address/data widths and the request record
// used by both the W-stage path and the MDU result queue.
package grf_write_arbiter_pkg;

  localparam int GRF_AW = 5;
  localparam int GRF_DW = 32;

  typedef struct packed {
    logic [GRF_AW-1:0] a3;
    logic [GRF_DW-1:0] wd;
    logic [GRF_DW-1:0] pc;
  } wb_req_t;

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Bus between the writeback producers / stall unit (master) and the GRF
// write arbiter (slave). The arbiter drives the GRF write port signals.
interface grf_write_arbiter_if;
  import grf_write_arbiter_pkg::*;

  logic              pipe_we;
  logic [GRF_AW-1:0] pipe_a3;
  logic [GRF_DW-1:0] pipe_wd;
  logic [GRF_DW-1:0] pipe_pc;

  logic              mdu_valid;
  logic              mdu_ready;
  logic [GRF_AW-1:0] mdu_a3;
  logic [GRF_DW-1:0] mdu_wd;
  logic [GRF_DW-1:0] mdu_pc;

  logic [GRF_AW-1:0] q1;
  logic [GRF_AW-1:0] q2;
  logic              pend1;
  logic              pend2;

  logic [GRF_AW-1:0] A3;
  logic [GRF_DW-1:0] WD;
  logic [GRF_DW-1:0] WPC;

  modport master (
    output pipe_we, pipe_a3, pipe_wd, pipe_pc,
    output mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    output q1, q2,
    input  mdu_ready, pend1, pend2, A3, WD, WPC
  );

  modport slave (
    input  pipe_we, pipe_a3, pipe_wd, pipe_pc,
    input  mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    input  q1, q2,
    output mdu_ready, pend1, pend2, A3, WD, WPC
  );

endinterface

// File: rtl/grf_write_arbiter_wb_req_fifo.sv
// MDU writeback queue: pointer FIFO with per-entry live bits that a younger
// pipe write can clear by address, plus two pending-address query ports.
module wb_req_fifo
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  wb_req_t           i_push_req,
  input  logic              i_pop,
  input  logic              i_kill,
  input  logic [GRF_AW-1:0] i_kill_a3,
  input  logic [GRF_AW-1:0] i_q1,
  input  logic [GRF_AW-1:0] i_q2,
  output logic              o_full,
  output logic              o_empty,
  output wb_req_t           o_head,
  output logic              o_head_live,
  output logic              o_pend1,
  output logic              o_pend2
);

  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;

  wb_req_t            r_mem [DEPTH];
  logic [DEPTH-1:0]   r_live;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;

  logic [PW-1:0]      w_wr_idx;
  logic [PW-1:0]      w_rd_idx;
  logic               w_hit1;
  logic               w_hit2;

  assign w_wr_idx    = r_wr_ptr[PW-1:0];
  assign w_rd_idx    = r_rd_ptr[PW-1:0];
  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (w_wr_idx == w_rd_idx);
  assign o_head      = r_mem[w_rd_idx];
  assign o_head_live = r_live[w_rd_idx];

  // NOTE: payload storage has no reset; only the live bits and pointers define
  // occupancy, so stale data in dead slots is never observed.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_push_req;
  end

  // NOTE: sequential state uses non-blocking assignments; the later push/pop
  // writes to r_live intentionally override the kill sweep for the same slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_live   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && r_live[i] && (r_mem[i].a3 == i_kill_a3)) r_live[i] <= 1'b0;
      end
      if (i_pop) begin
        r_live[w_rd_idx] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push) begin
        r_live[w_wr_idx] <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_mem[i].a3 == i_q1)) w_hit1 = 1'b1;
      if (r_live[i] && (r_mem[i].a3 == i_q2)) w_hit2 = 1'b1;
    end
  end

  assign o_pend1 = w_hit1 && (i_q1 != '0);
  assign o_pend2 = w_hit2 && (i_q2 != '0);

endmodule

// File: rtl/grf_write_arbiter.sv
// GRF single write port front end: W-stage writes win, queued MDU results
// fill idle cycles, and the port is a registered {A3, WD, WPC} (A3=0 = idle).
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  grf_write_arbiter_if.slave  bus
);

  wb_req_t w_pipe_req;
  wb_req_t w_mdu_req;
  wb_req_t w_head;
  logic    w_head_live;
  logic    w_full;
  logic    w_empty;
  logic    w_pipe_wr;
  logic    w_push;
  logic    w_pop;
  wb_req_t r_out;

  assign w_pipe_req = '{a3: bus.pipe_a3, wd: bus.pipe_wd, pc: bus.pipe_pc};
  assign w_mdu_req  = '{a3: bus.mdu_a3,  wd: bus.mdu_wd,  pc: bus.mdu_pc};

  // $0 requests complete their handshake but never occupy the port or queue.
  assign w_pipe_wr = bus.pipe_we && (bus.pipe_a3 != '0);
  assign w_push    = bus.mdu_valid && !w_full && (bus.mdu_a3 != '0);
  assign w_pop     = !w_pipe_wr && !w_empty;

  assign bus.mdu_ready = !w_full;

  wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_req  (w_mdu_req),
    .i_pop       (w_pop),
    .i_kill      (w_pipe_wr),
    .i_kill_a3   (bus.pipe_a3),
    .i_q1        (bus.q1),
    .i_q2        (bus.q2),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head),
    .o_head_live (w_head_live),
    .o_pend1     (bus.pend1),
    .o_pend2     (bus.pend2)
  );

  // A killed head still consumes its pop slot, leaving the port idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_pipe_wr) begin
      r_out <= w_pipe_req;
    end else if (w_pop && w_head_live) begin
      r_out <= w_head;
    end else begin
      r_out.a3 <= '0;
    end
  end

  assign bus.A3  = r_out.a3;
  assign bus.WD  = r_out.wd;
  assign bus.WPC = r_out.pc;

endmodule
